// File: rtl/spi_frame_matcher.sv
// Consumes the spi_slave byte stream and checks each CS-low frame on the fly
// against a fixed pattern. Reports a match pulse, a held match flag and an overrun flag.
module spi_frame_matcher #(
  parameter int unsigned                PATTERN_LEN = 16,
  parameter logic [8*PATTERN_LEN-1:0]   PATTERN     = {"SPI debug data", 8'h0D, 8'h0A}
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_data_ready,
  input  logic [7:0] spi_rx_data,
  output logic       spi_read_ack,
  output logic       match_pulse,
  output logic       match_flag,
  output logic       overrun_flag,
  output logic [5:0] byte_count
);

  localparam int unsigned IdxW     = $clog2(PATTERN_LEN + 1);
  localparam int unsigned PatDepth = 2 ** IdxW;
  localparam logic [IdxW-1:0] LenIdx  = IdxW'(PATTERN_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PATTERN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StAck, StWaitLow} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            ok_q, ok_d;
  logic [5:0]      count_q, count_d;
  logic            pulse_q, pulse_d;
  logic            flag_q, flag_d;
  logic            ovr_q, ovr_d;
  logic            in_frame_q, in_frame_d;
  logic            cs_meta_q, cs_sync_q, cs_prev_q;
  logic            frame_start, frame_end;
  logic            ok_next;

  // Pattern bytes padded to a power-of-two depth so idx indexes it without width games.
  logic [7:0] pat_byte [PatDepth];
  for (genvar i = 0; i < int'(PatDepth); i++) begin : g_pat
    if (i < int'(PATTERN_LEN)) begin : g_used
      assign pat_byte[i] = PATTERN[8*(int'(PATTERN_LEN)-1-i) +: 8];
    end else begin : g_pad
      assign pat_byte[i] = 8'h00;
    end
  end

  // Synchroniser clears to 0 so a CS held low across reset never looks like a new frame.
  assign frame_start = cs_prev_q & ~cs_sync_q;
  assign frame_end   = ~cs_prev_q & cs_sync_q;
  assign ok_next     = ok_q & (spi_rx_data == pat_byte[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ok_d       = ok_q;
    count_d    = count_q;
    pulse_d    = 1'b0;
    flag_d     = flag_q;
    ovr_d      = ovr_q;
    in_frame_d = in_frame_q;

    if (frame_start) begin
      in_frame_d = 1'b1;
      idx_d      = '0;
      ok_d       = 1'b1;
      count_d    = '0;
      flag_d     = 1'b0;
      ovr_d      = 1'b0;
    end else if (frame_end) begin
      in_frame_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StRecv;
        end else if (spi_data_ready) begin
          state_d = StAck;
        end
      end
      StRecv: begin
        if (frame_end) begin
          state_d = StIdle;
        end else if (spi_data_ready) begin
          state_d = StAck;
          if (idx_q < LenIdx) begin
            ok_d  = ok_next;
            idx_d = idx_q + 1'b1;
            if ((idx_q == LastIdx) && ok_next) begin
              pulse_d = 1'b1;
              flag_d  = 1'b1;
            end
          end else begin
            ovr_d  = 1'b1;
            flag_d = 1'b0;
          end
          if (count_q != 6'd63) begin
            count_d = count_q + 6'd1;
          end
        end
      end
      StAck: begin
        // Out-of-frame acks and acks cut short by CS rising return straight to idle.
        if ((in_frame_q || frame_start) && !frame_end) begin
          state_d = StWaitLow;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitLow: begin
        if (frame_end) begin
          state_d = StIdle;
        end else if (!spi_data_ready) begin
          state_d = in_frame_q ? StRecv : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ok_q       <= 1'b1;
      count_q    <= '0;
      pulse_q    <= 1'b0;
      flag_q     <= 1'b0;
      ovr_q      <= 1'b0;
      in_frame_q <= 1'b0;
      cs_meta_q  <= 1'b0;
      cs_sync_q  <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ok_q       <= ok_d;
      count_q    <= count_d;
      pulse_q    <= pulse_d;
      flag_q     <= flag_d;
      ovr_q      <= ovr_d;
      in_frame_q <= in_frame_d;
      cs_meta_q  <= spi_cs;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
    end
  end

  assign spi_read_ack = (state_q == StAck);
  assign match_pulse  = pulse_q;
  assign match_flag   = flag_q;
  assign overrun_flag = ovr_q;
  assign byte_count   = count_q;

endmodule

// File: tb/tb_spi_frame_matcher.sv
// Self-checking bench: drives SPI frames through a spi_slave-like handshake and compares
// the outcome with a frame-level reference model.
module tb_spi_frame_matcher;

  localparam int unsigned PLen = 16;
  localparam logic [8*PLen-1:0] Pat = {"SPI debug data", 8'h0D, 8'h0A};

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs;
  logic       spi_data_ready;
  logic [7:0] spi_rx_data;
  logic       spi_read_ack;
  logic       match_pulse;
  logic       match_flag;
  logic       overrun_flag;
  logic [5:0] byte_count;

  always #5 clk = ~clk;

  spi_frame_matcher #(
    .PATTERN_LEN (PLen),
    .PATTERN     (Pat)
  ) dut (
    .system_clk     (clk),
    .reset          (reset),
    .spi_cs         (spi_cs),
    .spi_data_ready (spi_data_ready),
    .spi_rx_data    (spi_rx_data),
    .spi_read_ack   (spi_read_ack),
    .match_pulse    (match_pulse),
    .match_flag     (match_flag),
    .overrun_flag   (overrun_flag),
    .byte_count     (byte_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0;
  int pulse_cnt = 0;
  int pulse_ack_idx = 0;
  int double_ack = 0;
  int pulse_no_ack = 0;
  logic ack_prev = 1'b0;

  logic [8*PLen-1:0] pat_v;
  logic [7:0] pat_b [PLen];
  logic [7:0] frm [64];
  int frm_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor sampling 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (spi_read_ack) begin
      ack_cnt++;
      if (ack_prev) double_ack++;
    end
    if (match_pulse) begin
      pulse_cnt++;
      pulse_ack_idx = ack_cnt;
      if (!spi_read_ack) pulse_no_ack++;
    end
    ack_prev = spi_read_ack;
  end

  // spi_slave-like producer: holds ready two cycles past the ack (late drop).
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    spi_rx_data = b;
    spi_data_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (spi_read_ack) got = 1'b1;
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    spi_data_ready = 1'b0;
    spi_rx_data = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    bit   exp_match;
    int   ack_base;
    int   pulse_base;
    int   exp_cnt;
    exp_match = (frm_len >= int'(PLen));
    for (int i = 0; i < int'(PLen) && i < frm_len; i++) begin
      if (frm[i] != pat_b[i]) exp_match = 1'b0;
    end
    exp_cnt = (frm_len > 63) ? 63 : frm_len;
    ack_base = ack_cnt;
    pulse_base = pulse_cnt;

    spi_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < frm_len; i++) send_byte(frm[i]);
    check_eq({tag, "_flag_in"}, 32'(match_flag), 32'(exp_match && frm_len == int'(PLen)));
    check_eq({tag, "_ovr_in"}, 32'(overrun_flag), 32'(frm_len > int'(PLen)));

    spi_cs = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq({tag, "_acks"}, 32'(ack_cnt - ack_base), 32'(frm_len));
    check_eq({tag, "_pulses"}, 32'(pulse_cnt - pulse_base), 32'(exp_match));
    if (exp_match) check_eq({tag, "_pulse_pos"}, 32'(pulse_ack_idx - ack_base), 32'(PLen));
    check_eq({tag, "_count"}, 32'(byte_count), 32'(exp_cnt));
    check_eq({tag, "_flag_end"}, 32'(match_flag), 32'(exp_match && frm_len == int'(PLen)));
    check_eq({tag, "_ovr_end"}, 32'(overrun_flag), 32'(frm_len > int'(PLen)));
  endtask

  task automatic load_good(input int n);
    frm_len = n;
    for (int i = 0; i < n; i++) frm[i] = (i < int'(PLen)) ? pat_b[i] : 8'h00;
  endtask

  initial begin
    int pos;
    pat_v = Pat;
    for (int i = 0; i < int'(PLen); i++) pat_b[i] = pat_v[8*(int'(PLen)-1-i) +: 8];

    reset = 1'b1;
    spi_cs = 1'b1;
    spi_data_ready = 1'b1;
    spi_rx_data = 8'hA5;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_ack", 32'(spi_read_ack), 32'd0);
      check_eq("rst_outs", 32'({match_pulse, match_flag, overrun_flag, byte_count}), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("oof_ack", 32'(spi_read_ack), 32'd1);
    spi_data_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("oof_ack_once", 32'(spi_read_ack), 32'd0);
    check_eq("oof_count", 32'(byte_count), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    load_good(16);
    run_frame("good");

    load_good(16);
    frm[5] = 8'h45;
    run_frame("bad5");

    load_good(17);
    run_frame("over17");

    load_good(10);
    run_frame("short10");
    load_good(16);
    run_frame("good2");

    // New falling CS edge after a match: flag survives two cycles, clears on the third.
    spi_cs = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("cs_fall_flag_held", 32'(match_flag), 32'd1);
    @(posedge clk);
    #1;
    check_eq("cs_fall_flag_clr", 32'(match_flag), 32'd0);
    check_eq("cs_fall_count_clr", 32'(byte_count), 32'd0);
    spi_cs = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int f = 0; f < 10; f++) begin
      frm_len = $urandom_range(1, 20);
      for (int i = 0; i < frm_len; i++) frm[i] = (i < int'(PLen)) ? pat_b[i] : 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pos = $urandom_range(0, frm_len - 1);
        frm[pos] = frm[pos] ^ 8'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 3) == 0) load_good(16);
      run_frame("rnd");
    end

    check_eq("double_ack", 32'(double_ack), 32'd0);
    check_eq("pulse_without_ack", 32'(pulse_no_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
